// File: rtl/puf_response_ctrl.sv
// Sequences two counter-equipped ring oscillators through one challenge slice per bit.
// Each bit runs clear, run, stop and compare phases, and the final response is published in DONE.
module puf_response_ctrl #(
  parameter int N_BITS = 8,
  parameter int WINDOW = 50000,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [6*N_BITS-1:0]   challenge,
  input  logic [CNT_W-1:0]      count_a,
  input  logic [CNT_W-1:0]      count_b,
  output logic                  ro_enable,
  output logic                  ro_reset,
  output logic [2:0]            ro_sel,
  output logic [2:0]            ro_bx,
  output logic                  busy,
  output logic                  done,
  output logic [N_BITS-1:0]     response,
  output logic                  tie,
  output logic                  sat
);

  localparam int PH_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int IDX_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE - 1);
  localparam logic [PH_W-1:0]  WINDOW_LAST = PH_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_STOP,
    S_CMP,
    S_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [PH_W-1:0]       phase_reg, phase_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [6*N_BITS-1:0]   chal_reg, chal_next;
  logic [N_BITS-1:0]     work_reg, work_next;
  logic                  wtie_reg, wtie_next;
  logic                  wsat_reg, wsat_next;

  logic                  ro_enable_reg, ro_enable_next;
  logic                  ro_reset_reg, ro_reset_next;
  logic [2:0]            ro_sel_reg, ro_sel_next;
  logic [2:0]            ro_bx_reg, ro_bx_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic [N_BITS-1:0]     response_reg, response_next;
  logic                  tie_reg, tie_next;
  logic                  sat_reg, sat_next;

  // Slices come from the next-cycle challenge copy so the registered RO controls
  // already carry the right slice in the first cycle of CLR.
  logic [5:0] slice [N_BITS];

  generate
    for (genvar gi = 0; gi < N_BITS; gi++) begin : g_slice
      assign slice[gi] = chal_next[6*gi +: 6];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      phase_reg     <= '0;
      idx_reg       <= '0;
      chal_reg      <= '0;
      work_reg      <= '0;
      wtie_reg      <= 1'b0;
      wsat_reg      <= 1'b0;
      ro_enable_reg <= 1'b0;
      ro_reset_reg  <= 1'b1;
      ro_sel_reg    <= 3'd0;
      ro_bx_reg     <= 3'd0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      response_reg  <= '0;
      tie_reg       <= 1'b0;
      sat_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      idx_reg       <= idx_next;
      chal_reg      <= chal_next;
      work_reg      <= work_next;
      wtie_reg      <= wtie_next;
      wsat_reg      <= wsat_next;
      ro_enable_reg <= ro_enable_next;
      ro_reset_reg  <= ro_reset_next;
      ro_sel_reg    <= ro_sel_next;
      ro_bx_reg     <= ro_bx_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      response_reg  <= response_next;
      tie_reg       <= tie_next;
      sat_reg       <= sat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    idx_next   = idx_reg;
    chal_next  = chal_reg;
    work_next  = work_reg;
    wtie_next  = wtie_reg;
    wsat_next  = wsat_reg;

    case (state_reg)
      S_IDLE: begin
        if (start && !abort) begin
          chal_next  = challenge;
          idx_next   = '0;
          work_next  = '0;
          wtie_next  = 1'b0;
          wsat_next  = 1'b0;
          phase_next = SETTLE_LAST;
          state_next = S_CLR;
        end
      end
      S_CLR: begin
        if (phase_reg == '0) begin
          phase_next = WINDOW_LAST;
          state_next = S_RUN;
        end else begin
          phase_next = phase_reg - 1'b1;
        end
      end
      S_RUN: begin
        if (phase_reg == '0) begin
          phase_next = SETTLE_LAST;
          state_next = S_STOP;
        end else begin
          phase_next = phase_reg - 1'b1;
        end
      end
      S_STOP: begin
        if (phase_reg == '0) begin
          state_next = S_CMP;
        end else begin
          phase_next = phase_reg - 1'b1;
        end
      end
      S_CMP: begin
        work_next[idx_reg] = (count_a > count_b);
        wtie_next = wtie_reg | (count_a == count_b);
        wsat_next = wsat_reg | (count_a == '1) | (count_b == '1);
        if (idx_reg == IDX_LAST) begin
          state_next = S_DONE;
        end else begin
          idx_next   = idx_reg + 1'b1;
          phase_next = SETTLE_LAST;
          state_next = S_CLR;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort overrides every transition out of a busy state, including DONE.
    if (abort && (state_reg != S_IDLE)) begin
      state_next = S_IDLE;
    end
  end

  // Output registers are loaded from the next state so every output is a flop.
  always_comb begin
    ro_enable_next = (state_next == S_RUN);
    ro_reset_next  = (state_next == S_IDLE) || (state_next == S_CLR) || (state_next == S_DONE);
    busy_next      = (state_next != S_IDLE);
    done_next      = (state_next == S_DONE);
    ro_sel_next    = 3'd0;
    ro_bx_next     = 3'd0;
    response_next  = response_reg;
    tie_next       = tie_reg;
    sat_next       = sat_reg;

    if (state_next != S_IDLE) begin
      ro_sel_next = slice[idx_next][5:3];
      ro_bx_next  = slice[idx_next][2:0];
    end

    if (state_next == S_DONE) begin
      response_next = work_next;
      tie_next      = wtie_next;
      sat_next      = wsat_next;
    end
  end

  assign ro_enable = ro_enable_reg;
  assign ro_reset  = ro_reset_reg;
  assign ro_sel    = ro_sel_reg;
  assign ro_bx     = ro_bx_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign response  = response_reg;
  assign tie       = tie_reg;
  assign sat       = sat_reg;

endmodule

// File: tb/tb_puf_response_ctrl.sv
// Bench for puf_response_ctrl: behavioural RO counters keyed on {sel,bx}, with scoreboard queues
// for done results and per-bit slices, checked by an independent monitor.
module tb_puf_response_ctrl;

  localparam int N_BITS = 4;
  localparam int WINDOW = 10;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 16;
  localparam int P      = 2*SETTLE + WINDOW + 1;

  // Slices written in octal so each digit pair reads directly as {sel,bx}.
  localparam logic [23:0] CHAL = {6'o75, 6'o32, 6'o21, 6'o10};

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [6*N_BITS-1:0] challenge = '0;
  logic [CNT_W-1:0]    count_a, count_b;
  logic                ro_enable, ro_reset, busy, done, tie, sat;
  logic [2:0]          ro_sel, ro_bx;
  logic [N_BITS-1:0]   response;

  puf_response_ctrl #(
    .N_BITS(N_BITS), .WINDOW(WINDOW), .SETTLE(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .challenge(challenge),
    .count_a(count_a), .count_b(count_b), .ro_enable(ro_enable), .ro_reset(ro_reset),
    .ro_sel(ro_sel), .ro_bx(ro_bx), .busy(busy), .done(done), .response(response),
    .tie(tie), .sat(sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter model: counts enabled cycles; reports the table value for the applied
  // {sel,bx} only after exactly WINDOW enabled cycles, otherwise the raw cycle count.
  logic [15:0] tab_a [64];
  logic [15:0] tab_b [64];
  logic [15:0] en_cnt = '0;
  always @(posedge clk) en_cnt <= ro_reset ? 16'd0 : (ro_enable ? en_cnt + 16'd1 : en_cnt);
  assign count_a = (en_cnt == 16'(WINDOW)) ? tab_a[{ro_sel, ro_bx}] : en_cnt;
  assign count_b = (en_cnt == 16'(WINDOW)) ? tab_b[{ro_sel, ro_bx}] : en_cnt;

  typedef struct {
    logic [N_BITS-1:0] resp;
    logic              tie;
    logic              sat;
    int                cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [5:0] slice_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: slice at each RUN start, enable length at each RUN end, result at done.
  initial begin : monitor
    logic en_prev;
    int   run_len;
    exp_t e;
    logic [5:0] s;
    en_prev = 1'b0;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (ro_enable) begin
        if (!en_prev) begin
          if (slice_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_run: got sel/bx=%0o%0o required no run", ro_sel, ro_bx);
          end else begin
            s = slice_q.pop_front();
            chk("ro_sel", 32'(ro_sel), 32'(s[5:3]));
            chk("ro_bx", 32'(ro_bx), 32'(s[2:0]));
          end
        end
        run_len++;
      end else begin
        if (en_prev && busy) chk("enable_len", 32'(run_len), 32'(WINDOW));
        run_len = 0;
      end
      en_prev = ro_enable;
      if (done) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done=1 required no done");
        end else begin
          e = sb_q.pop_front();
          $display("done: response=%b tie=%b sat=%b cycle=%0d", response, tie, sat, cyc);
          chk("response", 32'(response), 32'(e.resp));
          chk("tie", 32'(tie), 32'(e.tie));
          chk("sat", 32'(sat), 32'(e.sat));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic set_tab(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 64; i++) begin
      tab_a[i] = a;
      tab_b[i] = b;
    end
  endtask

  // Issues start; pushes the slice expectations and, if requested, the done result.
  task automatic start_eval(input logic [23:0] chal, input bit push_sb,
                            input logic [N_BITS-1:0] resp, input logic t, input logic s,
                            output int t_cyc);
    exp_t e;
    @(negedge clk);
    challenge = chal;
    start = 1'b1;
    for (int i = 0; i < N_BITS; i++) slice_q.push_back(chal[6*i +: 6]);
    @(posedge clk);
    #1;
    start = 1'b0;
    challenge = 24'h5A5A5A;
    t_cyc = cyc;
    if (push_sb) begin
      e.resp = resp; e.tie = t; e.sat = s; e.cyc = t_cyc + N_BITS*P;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while ((sb_q.size() != 0) && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got no done within 200 cycles required done", nm);
      sb_q.delete();
      slice_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_eval(input string nm, input logic [23:0] chal, input logic [N_BITS-1:0] resp,
                          input logic t, input logic s, input bit pulse_mid);
    int t_cyc;
    start_eval(chal, 1'b1, resp, t, s, t_cyc);
    if (pulse_mid) begin
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_drain(nm);
  endtask

  initial begin : stim
    int t_cyc;
    set_tab(16'd100, 16'd90);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ro_enable", 32'(ro_enable), 32'd0);
    chk("rst_ro_reset", 32'(ro_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_response", 32'(response), 32'd0);
    chk("rst_sel_bx", 32'({ro_sel, ro_bx}), 32'd0);
    chk("rst_tie_sat", 32'({tie, sat}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // A > B on every bit
    run_eval("all_a_gt_b", CHAL, 4'b1111, 1'b0, 1'b0, 1'b0);

    // A > B only for slices {2,1} and {7,5}
    set_tab(16'd90, 16'd100);
    tab_a[6'o21] = 16'd100; tab_b[6'o21] = 16'd90;
    tab_a[6'o75] = 16'd100; tab_b[6'o75] = 16'd90;
    run_eval("slice_map", CHAL, 4'b1010, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RUN
    start_eval(CHAL, 1'b0, '0, 1'b0, 1'b0, t_cyc);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrun_ro_enable", 32'(ro_enable), 32'd0);
    chk("midrun_ro_reset", 32'(ro_reset), 32'd1);
    chk("midrun_busy", 32'(busy), 32'd0);
    chk("midrun_response", 32'(response), 32'd0);
    slice_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Tie on bit 2, saturated count on bit 0
    set_tab(16'd100, 16'd90);
    tab_a[6'o10] = 16'hFFFF; tab_b[6'o10] = 16'd10;
    tab_a[6'o32] = 16'd55;   tab_b[6'o32] = 16'd55;
    run_eval("tie_sat", CHAL, 4'b1011, 1'b1, 1'b1, 1'b0);

    // Abort during bit 1 RUN; response must keep its prior value
    start_eval(CHAL, 1'b0, '0, 1'b0, 1'b0, t_cyc);
    repeat (P + 4) @(negedge clk);
    chk("abort_in_run", 32'(ro_enable), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ro_enable", 32'(ro_enable), 32'd0);
    chk("abort_ro_reset", 32'(ro_reset), 32'd1);
    chk("abort_response", 32'(response), 32'(4'b1011));
    slice_q.delete();
    repeat (80) @(negedge clk);
    chk("abort_no_done_hold", 32'({response, tie, sat}), 32'({4'b1011, 1'b1, 1'b1}));
    set_tab(16'd90, 16'd100);
    tab_a[6'o21] = 16'd100; tab_b[6'o21] = 16'd90;
    tab_a[6'o75] = 16'd100; tab_b[6'o75] = 16'd90;
    run_eval("after_abort", CHAL, 4'b1010, 1'b0, 1'b0, 1'b0);

    // start together with abort in IDLE is ignored
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    // start pulsed while busy leaves timing and result untouched
    set_tab(16'd100, 16'd90);
    run_eval("start_while_busy", CHAL, 4'b1111, 1'b0, 1'b0, 1'b1);
    chk("slices_consumed", 32'(slice_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
